if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage, directly upstream of the decode stage.
- Owns the architectural fetch PC and drives read addresses to the synchronous-read BIOS and IMEM.
- Presents `id_pc` aligned with the memory read data that decode consumes.
- Resolves next-PC priority between reset, MEM-stage flush redirect, decode stall hold, decode-predicted target and sequential PC+4.

Parameters:
- RESET_PC, 32'h4000_0000, fetch address after reset (BIOS region; PC[30]=1 selects BIOS).
- BIOS_AW, 12, BIOS word-address width.
- IMEM_AW, 14, IMEM word-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_stall  in  1  decode cannot accept a new instruction; hold fetch.
- mem_flush  in  1  MEM-stage misprediction/flush; redirect fetch.
- mem_redirect_pc  in  32  correct PC when mem_flush=1.
- ex_target_taken  in  1  decode-predicted control transfer is being applied.
- ex_target  in  32  predicted target PC.
- bios_addr  out  BIOS_AW  BIOS word read address (next_pc[BIOS_AW+1:2]).
- imem_addr  out  IMEM_AW  IMEM word read address (next_pc[IMEM_AW+1:2]).
- id_pc  out  32  PC of the instruction currently on the memory outputs.
- id_valid  out  1  id_pc/memory data correspond to a real fetch.
- fetch_misaligned  out  1  sticky: a redirect target had bits [1:0] != 0.
- stat_fetch  out  32  fetched-instruction count (optional feature).
- stat_redirect  out  32  redirect count (optional feature).
- stat_stall  out  32  stall-cycle count (optional feature).

Behaviour:
- next_pc is combinational, first match wins:
  - rst → RESET_PC
  - mem_flush → mem_redirect_pc
  - id_stall → id_pc
  - ex_target_taken → ex_target
  - otherwise → id_pc+4, wrapping modulo 2^32.
- next_pc[1:0] is forced to 2'b00 before use.
- bios_addr and imem_addr are both driven from next_pc every cycle. Decode selects between them using id_pc[30].
- id_pc <= next_pc every cycle. Memory data for id_pc is therefore valid in the cycle id_pc holds it (1-cycle fetch latency).
- Stall hold: re-presenting id_pc keeps the synchronous-read memory outputs stable, so there is no replay buffer.
- Two-state FSM:
  - RESET (entered on rst): id_valid=0.
  - RESET → RUN on the first cycle with rst=0.
  - In RUN, id_valid=1.
  - rst in any state → RESET. Reset mid-stall or mid-redirect discards the pending redirect.
- Reset values:
  - id_pc = RESET_PC
  - id_valid = 0
  - fetch_misaligned = 0
  - all stat counters = 0
- The first valid instruction is RESET_PC, presented in the cycle after rst deasserts.
- Simultaneous events:
  - mem_flush with id_stall: flush wins.
  - mem_flush with ex_target_taken: flush wins.
  - id_stall with ex_target_taken: stall wins, and the target is not lost because decode holds ex_target_taken while stalled.
- fetch_misaligned is set when the selected redirect source (mem_redirect_pc or ex_target) has nonzero [1:0]. It clears only on rst.
- No out-of-range detection. Addresses outside the BIOS/IMEM regions fetch whatever the truncated address returns.

Optional Feature:
- Macro: IF_STAGE_STATS_EN.
- When defined:
  - stat_fetch increments each RUN cycle without id_stall.
  - stat_redirect increments each cycle mem_flush or ex_target_taken is selected.
  - stat_stall increments each RUN cycle with id_stall.
  - All three are 32-bit, wrap at 2^32, and reset to 0.
- When undefined: the counters are not instantiated and the three stat ports are tied to 0.

Test Plan:
- Reset sequence: hold rst 3 cycles then release → id_pc=0x4000_0000 with id_valid=0 during reset; first valid cycle id_pc=0x4000_0000; following cycles 0x4000_0004, 0x4000_0008.
- Stall hold: id_stall=1 for 3 cycles at id_pc=0x1000_0010 → id_pc and imem_addr (0x004) constant; sequential fetch resumes at 0x1000_0014 after release.
- Predicted target: ex_target_taken=1, ex_target=0x1000_0100 → next id_pc=0x1000_0100, then 0x1000_0104.
- Flush priority: mem_flush=1 (redirect 0x4000_0020) together with id_stall=1 and ex_target_taken=1 (target 0x1000_0000) → id_pc=0x4000_0020.
- Misalignment: ex_target=0x1000_0102 taken → id_pc=0x1000_0100, fetch_misaligned=1, sticky until rst.
- Stats (IF_STAGE_STATS_EN defined): 10 run cycles, 2 stalled, 1 redirect → stat_fetch=8, stat_stall=2, stat_redirect=1. With the macro undefined all three read 0.

Source files
------------

// File: rtl/if_stage_if.sv
// Fetch-stage interface: decode/MEM control into fetch, fetch addresses and
// PC/status out toward the memories and decode.
interface if_stage_if #(
   parameter int unsigned BIOS_AW = 12,
   parameter int unsigned IMEM_AW = 14
);
   logic                 id_stall;
   logic                 mem_flush;
   logic [31:0]          mem_redirect_pc;
   logic                 ex_target_taken;
   logic [31:0]          ex_target;
   logic [BIOS_AW-1:0]   bios_addr;
   logic [IMEM_AW-1:0]   imem_addr;
   logic [31:0]          id_pc;
   logic                 id_valid;
   logic                 fetch_misaligned;
   logic [31:0]          stat_fetch;
   logic [31:0]          stat_redirect;
   logic [31:0]          stat_stall;

   // Fetch stage side
   modport slave (
      input  id_stall, mem_flush, mem_redirect_pc, ex_target_taken, ex_target,
      output bios_addr, imem_addr, id_pc, id_valid, fetch_misaligned,
             stat_fetch, stat_redirect, stat_stall
   );

   // Pipeline / environment side
   modport master (
      output id_stall, mem_flush, mem_redirect_pc, ex_target_taken, ex_target,
      input  bios_addr, imem_addr, id_pc, id_valid, fetch_misaligned,
             stat_fetch, stat_redirect, stat_stall
   );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives BIOS/IMEM read addresses
// and presents id_pc aligned with synchronous-read memory data.
// Optional statistics counters enabled by defining IF_STAGE_STATS_EN.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h4000_0000,
   parameter int unsigned BIOS_AW  = 12,
   parameter int unsigned IMEM_AW  = 14
) (
   input  logic         clk,
   input  logic         rst,
   if_stage_if.slave    bus
);

   typedef enum logic {ST_RESET = 1'b0, ST_RUN = 1'b1} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_id_valid;
   logic          w_id_valid_nxt;
   logic [31:0]   r_id_pc;
   logic          r_misaligned;
   logic [31:0]   w_next_raw;
   logic [31:0]   w_next_pc;
   logic          w_sel_redirect;
   logic          w_redirect_misaligned;

   // Next-PC priority; the RESET state re-presents RESET_PC so its data is
   // still on the memory outputs in the first valid cycle.
   always_comb begin
      w_next_raw     = r_id_pc + 32'd4;
      w_sel_redirect = 1'b0;
      if (rst || (r_state == ST_RESET)) begin
         w_next_raw = RESET_PC;
      end else if (bus.mem_flush) begin
         w_next_raw     = bus.mem_redirect_pc;
         w_sel_redirect = 1'b1;
      end else if (bus.id_stall) begin
         w_next_raw = r_id_pc;
      end else if (bus.ex_target_taken) begin
         w_next_raw     = bus.ex_target;
         w_sel_redirect = 1'b1;
      end
      w_redirect_misaligned = w_sel_redirect && (w_next_raw[1:0] != 2'b00);
      w_next_pc             = {w_next_raw[31:2], 2'b00};
   end

   // FSM next state and id_valid
   always_comb begin
      w_state_nxt    = r_state;
      w_id_valid_nxt = 1'b0;
      case (r_state)
         ST_RESET: w_state_nxt = ST_RUN;
         ST_RUN:   w_state_nxt = ST_RUN;
         default:  w_state_nxt = ST_RESET;
      endcase
      if (rst) begin
         w_state_nxt = ST_RESET;
      end
      w_id_valid_nxt = (w_state_nxt == ST_RUN);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_RESET;
         r_id_valid <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_id_valid <= w_id_valid_nxt;
      end
   end

   // Fetch PC and sticky misalignment flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_id_pc      <= RESET_PC;
         r_misaligned <= 1'b0;
      end else begin
         r_id_pc <= w_next_pc;
         if (w_redirect_misaligned) begin
            r_misaligned <= 1'b1;
         end
      end
   end

   assign bus.bios_addr        = w_next_pc[BIOS_AW+1:2];
   assign bus.imem_addr        = w_next_pc[IMEM_AW+1:2];
   assign bus.id_pc            = r_id_pc;
   assign bus.id_valid         = r_id_valid;
   assign bus.fetch_misaligned = r_misaligned;

`ifdef IF_STAGE_STATS_EN
   logic [31:0] r_stat_fetch;
   logic [31:0] r_stat_redirect;
   logic [31:0] r_stat_stall;

   // Fetch, redirect and stall-cycle counters (wrap at 2^32)
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_fetch    <= 32'd0;
         r_stat_redirect <= 32'd0;
         r_stat_stall    <= 32'd0;
      end else if (r_state == ST_RUN) begin
         if (bus.id_stall) begin
            r_stat_stall <= r_stat_stall + 32'd1;
         end else begin
            r_stat_fetch <= r_stat_fetch + 32'd1;
         end
         if (w_sel_redirect) begin
            r_stat_redirect <= r_stat_redirect + 32'd1;
         end
      end
   end

   assign bus.stat_fetch    = r_stat_fetch;
   assign bus.stat_redirect = r_stat_redirect;
   assign bus.stat_stall    = r_stat_stall;
`else
   assign bus.stat_fetch    = 32'd0;
   assign bus.stat_redirect = 32'd0;
   assign bus.stat_stall    = 32'd0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage.
module tb_if_stage;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   if_stage_if bus ();

   if_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.id_stall        = 1'b0;
      bus.mem_flush       = 1'b0;
      bus.mem_redirect_pc = 32'h0;
      bus.ex_target_taken = 1'b0;
      bus.ex_target       = 32'h0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      logic [31:0] exp_pc;
      idle_inputs();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (bus.id_pc !== 32'h4000_0000 || bus.id_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold cyc=%0d id_pc=%h id_valid=%b expected 40000000/0", i, bus.id_pc, bus.id_valid);
         end
      end
      checks++;
      if (bus.bios_addr !== 12'h000 || bus.fetch_misaligned !== 1'b0) begin
         failures++;
         $display("FAIL reset_addr bios_addr=%h misaligned=%b expected 000/0", bus.bios_addr, bus.fetch_misaligned);
      end
      rst = 1'b0;
      exp_pc = 32'h4000_0000;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (bus.id_pc !== exp_pc || bus.id_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_seq cyc=%0d id_pc=%h id_valid=%b expected %h/1", i, bus.id_pc, bus.id_valid, exp_pc);
         end
         exp_pc = exp_pc + 32'd4;
      end
      checks++;
      if (bus.bios_addr !== 12'h003 || bus.imem_addr !== 14'h0003) begin
         failures++;
         $display("FAIL seq_addr bios_addr=%h imem_addr=%h expected 003/0003", bus.bios_addr, bus.imem_addr);
      end
   endtask

   task automatic test_stall();
      bus.ex_target_taken = 1'b1;
      bus.ex_target       = 32'h1000_0010;
      step();
      bus.ex_target_taken = 1'b0;
      bus.id_stall        = 1'b1;
      #1;
      checks++;
      if (bus.id_pc !== 32'h1000_0010 || bus.imem_addr !== 14'h0004) begin
         failures++;
         $display("FAIL stall_entry id_pc=%h imem_addr=%h expected 10000010/0004", bus.id_pc, bus.imem_addr);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (bus.id_pc !== 32'h1000_0010 || bus.imem_addr !== 14'h0004 || bus.id_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold cyc=%0d id_pc=%h imem_addr=%h valid=%b expected 10000010/0004/1", i, bus.id_pc, bus.imem_addr, bus.id_valid);
         end
      end
      bus.id_stall = 1'b0;
      step();
      checks++;
      if (bus.id_pc !== 32'h1000_0014) begin
         failures++;
         $display("FAIL stall_release id_pc=%h expected 10000014", bus.id_pc);
      end
      // Stall beats a held target; the target applies once the stall drops.
      bus.id_stall        = 1'b1;
      bus.ex_target_taken = 1'b1;
      bus.ex_target       = 32'h1000_0200;
      step();
      checks++;
      if (bus.id_pc !== 32'h1000_0014) begin
         failures++;
         $display("FAIL stall_vs_target id_pc=%h expected 10000014", bus.id_pc);
      end
      bus.id_stall = 1'b0;
      step();
      idle_inputs();
      checks++;
      if (bus.id_pc !== 32'h1000_0200) begin
         failures++;
         $display("FAIL target_after_stall id_pc=%h expected 10000200", bus.id_pc);
      end
   endtask

   task automatic test_target();
      bus.ex_target_taken = 1'b1;
      bus.ex_target       = 32'h1000_0100;
      step();
      idle_inputs();
      checks++;
      if (bus.id_pc !== 32'h1000_0100) begin
         failures++;
         $display("FAIL target_jump id_pc=%h expected 10000100", bus.id_pc);
      end
      step();
      checks++;
      if (bus.id_pc !== 32'h1000_0104) begin
         failures++;
         $display("FAIL target_seq id_pc=%h expected 10000104", bus.id_pc);
      end
   endtask

   task automatic test_flush_priority();
      bus.mem_flush       = 1'b1;
      bus.mem_redirect_pc = 32'h4000_0020;
      bus.id_stall        = 1'b1;
      bus.ex_target_taken = 1'b1;
      bus.ex_target       = 32'h1000_0000;
      #1;
      checks++;
      if (bus.bios_addr !== 12'h008) begin
         failures++;
         $display("FAIL flush_bios_addr bios_addr=%h expected 008", bus.bios_addr);
      end
      step();
      idle_inputs();
      checks++;
      if (bus.id_pc !== 32'h4000_0020 || bus.fetch_misaligned !== 1'b0) begin
         failures++;
         $display("FAIL flush_priority id_pc=%h misaligned=%b expected 40000020/0", bus.id_pc, bus.fetch_misaligned);
      end
   endtask

   task automatic test_wrap();
      bus.ex_target_taken = 1'b1;
      bus.ex_target       = 32'hFFFF_FFFC;
      step();
      idle_inputs();
      step();
      checks++;
      if (bus.id_pc !== 32'h0000_0000) begin
         failures++;
         $display("FAIL pc_wrap id_pc=%h expected 00000000", bus.id_pc);
      end
   endtask

   task automatic test_misaligned();
      bus.ex_target_taken = 1'b1;
      bus.ex_target       = 32'h1000_0102;
      step();
      idle_inputs();
      checks++;
      if (bus.id_pc !== 32'h1000_0100 || bus.fetch_misaligned !== 1'b1) begin
         failures++;
         $display("FAIL misalign_set id_pc=%h misaligned=%b expected 10000100/1", bus.id_pc, bus.fetch_misaligned);
      end
      bus.mem_flush       = 1'b1;
      bus.mem_redirect_pc = 32'h4000_0040;
      step();
      idle_inputs();
      step();
      checks++;
      if (bus.fetch_misaligned !== 1'b1 || bus.id_pc !== 32'h4000_0044) begin
         failures++;
         $display("FAIL misalign_sticky misaligned=%b id_pc=%h expected 1/40000044", bus.fetch_misaligned, bus.id_pc);
      end
      // Reset during a stall with a pending flush discards the redirect.
      bus.id_stall        = 1'b1;
      bus.mem_flush       = 1'b1;
      bus.mem_redirect_pc = 32'h1000_0300;
      rst = 1'b1;
      step();
      checks++;
      if (bus.fetch_misaligned !== 1'b0 || bus.id_pc !== 32'h4000_0000 || bus.id_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_flush misaligned=%b id_pc=%h valid=%b expected 0/40000000/0", bus.fetch_misaligned, bus.id_pc, bus.id_valid);
      end
      rst = 1'b0;
      idle_inputs();
      step();
      checks++;
      if (bus.id_pc !== 32'h4000_0000 || bus.id_valid !== 1'b1) begin
         failures++;
         $display("FAIL reset_first_valid id_pc=%h valid=%b expected 40000000/1", bus.id_pc, bus.id_valid);
      end
   endtask

   task automatic test_stats();
      logic [31:0] exp_fetch;
      logic [31:0] exp_stall;
      logic [31:0] exp_redir;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         idle_inputs();
         if (i == 7 || i == 8) bus.id_stall = 1'b1;
         if (i == 9) begin
            bus.ex_target_taken = 1'b1;
            bus.ex_target       = 32'h1000_0000;
         end
         step();
      end
      idle_inputs();
`ifdef IF_STAGE_STATS_EN
      exp_fetch = 32'd8;
      exp_stall = 32'd2;
      exp_redir = 32'd1;
`else
      exp_fetch = 32'd0;
      exp_stall = 32'd0;
      exp_redir = 32'd0;
`endif
      checks++;
      if (bus.stat_fetch !== exp_fetch || bus.stat_stall !== exp_stall || bus.stat_redirect !== exp_redir) begin
         failures++;
         $display("FAIL stats fetch=%0d stall=%0d redirect=%0d expected %0d/%0d/%0d",
                  bus.stat_fetch, bus.stat_stall, bus.stat_redirect, exp_fetch, exp_stall, exp_redir);
      end
      checks++;
      if (bus.id_pc !== 32'h1000_0000) begin
         failures++;
         $display("FAIL stats_pc id_pc=%h expected 10000000", bus.id_pc);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (bus.stat_fetch !== 32'd0 || bus.stat_stall !== 32'd0 || bus.stat_redirect !== 32'd0) begin
         failures++;
         $display("FAIL stats_reset fetch=%0d stall=%0d redirect=%0d expected 0/0/0",
                  bus.stat_fetch, bus.stat_stall, bus.stat_redirect);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      idle_inputs();
      test_reset();
      test_stall();
      test_target();
      test_flush_priority();
      test_wrap();
      test_misaligned();
      test_stats();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
